booth_ctrl: RTL and testbench

- Sequencing controller that sits directly upstream of the 16-bit Booth multiplier datapath (A/Q/M registers, Q(-1) flop, add/sub ALU, 5-bit down-counter).
- Accepts an operand pair through a start handshake, latches it locally, and multiplexes multiplicand then multiplier onto the datapath's shared data input.
- Generates every datapath load, clear, shift, add/sub and count strobe, then captures the 32-bit product {A,Q} into an output buffer.
- Presents the product through a valid/ready handshake.

---
 rtl/booth_ctrl_pkg.sv | 9 +
 rtl/booth_ctrl_if.sv | 20 ++
 rtl/booth_ctrl_result_buf.sv | 23 ++
 rtl/booth_ctrl.sv | 80 ++++++++
 tb/tb_booth_ctrl.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/booth_ctrl_pkg.sv
// booth_pkg: shared state encoding and constants for the Booth multiplier controller
package booth_pkg;
   localparam int WIDTH = 16;
   localparam int CNT_W = 5;
   localparam int ITERATIONS = 16;
   localparam logic ADDSUB_SUB = 1'b0;
   localparam logic ADDSUB_ADD = 1'b1;
   typedef enum logic [2:0] {IDLE, LOAD_M, LOAD_Q, CHECK, ADD, SUB, SHIFT, RESULT} state_t;
endpackage

// File: rtl/booth_ctrl_if.sv
// booth_ctrl_if: operand request and product response handshake of the Booth controller
interface booth_ctrl_if;
   import booth_pkg::*;
   logic                 start;
   logic                 start_ready;
   logic [WIDTH-1:0]     multiplicand;
   logic [WIDTH-1:0]     multiplier;
   logic                 busy;
   logic [2*WIDTH-1:0]   product;
   logic                 res_valid;
   logic                 res_ready;
   modport master (
      output start, multiplicand, multiplier, res_ready,
      input  start_ready, busy, product, res_valid
   );
   modport slave (
      input  start, multiplicand, multiplier, res_ready,
      output start_ready, busy, product, res_valid
   );
endinterface

// File: rtl/booth_ctrl_result_buf.sv
// booth_result_buf: product register held with its valid flag until the consumer accepts
module booth_result_buf
   import booth_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load,
   input  logic [2*WIDTH-1:0]   din,
   input  logic                 ready,
   output logic                 valid,
   output logic [2*WIDTH-1:0]   dout
);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         valid <= 1'b0;
         dout  <= '0;
      end else if (load) begin
         valid <= 1'b1;
         dout  <= din;
      end else if (valid && ready) begin
         valid <= 1'b0;
      end
endmodule

// File: rtl/booth_ctrl.sv
// booth_ctrl: sequencer for a 16-bit Booth datapath; all strobes are Moore decodes of the state
module booth_ctrl
   import booth_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   booth_ctrl_if.slave        host,
   output logic [WIDTH-1:0]   data_out,
   output logic               lda,
   output logic               ldq,
   output logic               ldm,
   output logic               clra,
   output logic               clrq,
   output logic               clrff,
   output logic               sfta,
   output logic               sftq,
   output logic               decr,
   output logic               ldcnt,
   output logic               addsub,
   input  logic               q0,
   input  logic               qm1,
   input  logic               eqz,
   input  logic [WIDTH-1:0]   a_in,
   input  logic [WIDTH-1:0]   q_in
);
   state_t state, nxt;
   logic [WIDTH-1:0] mcand_q, mplier_q;
   logic accept, capture;
   assign accept  = state == IDLE && host.start;
   assign capture = state == CHECK && eqz;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state    <= IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
      end else begin
         state <= nxt;
         if (accept) begin
            mcand_q  <= host.multiplicand;
            mplier_q <= host.multiplier;
         end
      end
   // qm1 is only trusted in CHECK, which always directly follows LOAD_Q or SHIFT
   always_comb begin
      nxt = state;
      case (state)
         IDLE:     nxt = host.start ? LOAD_M : IDLE;
         LOAD_M:   nxt = LOAD_Q;
         LOAD_Q:   nxt = CHECK;
         CHECK:    nxt = eqz ? RESULT : (q0 && !qm1) ? SUB : (!q0 && qm1) ? ADD : SHIFT;
         ADD, SUB: nxt = SHIFT;
         SHIFT:    nxt = CHECK;
         RESULT:   nxt = host.res_ready ? IDLE : RESULT;
         default:  nxt = IDLE;
      endcase
   end
   assign data_out = state == LOAD_M ? mcand_q : state == LOAD_Q ? mplier_q : '0;
   assign ldm      = state == LOAD_M;
   assign clra     = state == LOAD_M;
   assign ldcnt    = state == LOAD_M;
   assign ldq      = state == LOAD_Q;
   assign clrff    = state == LOAD_Q;
   assign clrq     = 1'b0;
   assign lda      = state == ADD || state == SUB;
   assign addsub   = state == SUB ? ADDSUB_SUB : ADDSUB_ADD;
   assign sfta     = state == SHIFT;
   assign sftq     = state == SHIFT;
   assign decr     = state == SHIFT;
   assign host.start_ready = state == IDLE;
   assign host.busy        = state != IDLE && state != RESULT;
   booth_result_buf u_buf (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (capture),
      .din   ({a_in, q_in}),
      .ready (host.res_ready),
      .valid (host.res_valid),
      .dout  (host.product)
   );
endmodule

// File: tb/tb_booth_ctrl.sv
// tb_booth_ctrl: booth_ctrl bound to a guard-bit Booth datapath model, checked against signed multiplication
module tb_booth_ctrl;
   import booth_pkg::*;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   booth_ctrl_if bus ();
   logic [15:0] data_out, a_in, q_in;
   logic lda, ldq, ldm, clra, clrq, clrff, sfta, sftq, decr, ldcnt, addsub, q0, qm1, eqz;
   logic [9:0] strb;
   assign strb = {lda, ldq, ldm, clra, clrq, clrff, sfta, sftq, decr, ldcnt};
   booth_ctrl dut (
      .clk(clk), .rst_n(rst_n), .host(bus), .data_out(data_out),
      .lda(lda), .ldq(ldq), .ldm(ldm), .clra(clra), .clrq(clrq), .clrff(clrff),
      .sfta(sfta), .sftq(sftq), .decr(decr), .ldcnt(ldcnt), .addsub(addsub),
      .q0(q0), .qm1(qm1), .eqz(eqz), .a_in(a_in), .q_in(q_in)
   );
   // datapath: A carries a guard bit so that A-M cannot overflow for M = -32768
   logic [16:0] a_x;
   logic [15:0] m_r, q_r;
   logic qm1_r;
   logic [4:0] cnt;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         a_x <= '0; m_r <= '0; q_r <= '0; qm1_r <= 1'b0; cnt <= '0;
      end else begin
         qm1_r <= clrff ? 1'b0 : q_r[0];
         if (ldm) m_r <= data_out;
         if (ldq) q_r <= data_out;
         if (clrq) q_r <= '0;
         if (clra) a_x <= '0;
         if (ldcnt) cnt <= 5'd16;
         if (lda) a_x <= addsub ? a_x + {m_r[15], m_r} : a_x - {m_r[15], m_r};
         if (sfta && sftq) {a_x, q_r} <= {a_x[16], a_x, q_r[15:1]};
         if (decr) cnt <= cnt - 5'd1;
      end
   assign a_in = a_x[15:0];
   assign q_in = q_r;
   assign q0   = q_r[0];
   assign qm1  = qm1_r;
   assign eqz  = cnt == 5'd0;

   int n_cmp = 0;
   int n_bad = 0;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   function automatic int booth_ops(input logic [15:0] mp);
      int n = 0;
      logic prev = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (mp[i] != prev) n++;
         prev = mp[i];
      end
      return n;
   endfunction
   function automatic logic [31:0] smul(input logic [15:0] a, input logic [15:0] b);
      logic signed [31:0] p;
      p = 32'(signed'(a)) * 32'(signed'(b));
      return p;
   endfunction
   task automatic run_op(input logic [15:0] mc, input logic [15:0] mp, input logic rdy,
                         output logic [31:0] prod, output int lat, output int n_lda, output int n_decr);
      logic exp_op[$];
      logic prev = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (mp[i] != prev) exp_op.push_back(mp[i] ? ADDSUB_SUB : ADDSUB_ADD);
         prev = mp[i];
      end
      n_lda = 0;
      n_decr = 0;
      @(negedge clk);
      chk("start_ready_idle", {31'd0, bus.start_ready}, 32'd1);
      bus.start = 1'b1; bus.multiplicand = mc; bus.multiplier = mp; bus.res_ready = rdy;
      @(negedge clk);
      bus.start = 1'b0;
      lat = 1;
      while (!bus.res_valid && lat < 100) begin
         if (lda) begin
            n_lda++;
            if (exp_op.size() > 0) chk("addsub_op", {31'd0, addsub}, {31'd0, exp_op.pop_front()});
            else chk("extra_lda", {31'd0, lda}, 32'd0);
         end
         if (decr) n_decr++;
         @(negedge clk);
         lat++;
      end
      if (!bus.res_valid) chk("res_valid_timeout", {31'd0, bus.res_valid}, 32'd1);
      prod = bus.product;
   endtask

   typedef struct {logic [15:0] mc; logic [15:0] mp; logic [31:0] prod; int n;} vec_t;
   vec_t vecs[7];
   logic [31:0] prod;
   int lat, n_lda, n_decr, k;
   logic [15:0] rmc, rmp;

   initial begin
      vecs[0] = '{16'h0007, 16'hFFFD, 32'hFFFFFFEB, 3};
      vecs[1] = '{16'h1234, 16'h0000, 32'h00000000, 0};
      vecs[2] = '{16'h8000, 16'h8000, 32'h40000000, 1};
      vecs[3] = '{16'h0005, 16'h0006, 32'h0000001E, 2};
      vecs[4] = '{16'hFFFF, 16'hFFFF, 32'h00000001, 1};
      vecs[5] = '{16'h7FFF, 16'h7FFF, 32'h3FFF0001, 2};
      vecs[6] = '{16'h7FFF, 16'h8000, 32'hC0008000, 1};
      bus.start = 1'b0; bus.multiplicand = '0; bus.multiplier = '0; bus.res_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_start_ready", {31'd0, bus.start_ready}, 32'd1);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
      chk("rst_product", bus.product, 32'd0);
      chk("rst_strobes", {22'd0, strb}, 32'd0);
      chk("rst_addsub", {31'd0, addsub}, 32'd1);
      chk("rst_data_out", {16'd0, data_out}, 32'd0);
      rst_n = 1'b1;
      for (int v = 0; v < 7; v++) begin
         run_op(vecs[v].mc, vecs[v].mp, 1'b1, prod, lat, n_lda, n_decr);
         chk($sformatf("vec%0d_product", v), prod, vecs[v].prod);
         chk($sformatf("vec%0d_latency", v), lat, 36 + vecs[v].n);
         chk($sformatf("vec%0d_lda_count", v), n_lda, vecs[v].n);
         chk($sformatf("vec%0d_shift_count", v), n_decr, ITERATIONS);
      end
      // backpressure: RESULT held while new requests are offered
      run_op(16'h0007, 16'hFFFD, 1'b0, prod, lat, n_lda, n_decr);
      chk("bp_product", prod, 32'hFFFFFFEB);
      for (int i = 0; i < 10; i++) begin
         bus.start = 1'b1;
         bus.multiplicand = 16'($urandom);
         bus.multiplier = 16'($urandom);
         @(negedge clk);
         chk("bp_hold_product", bus.product, 32'hFFFFFFEB);
         chk("bp_start_ready", {31'd0, bus.start_ready}, 32'd0);
         chk("bp_strobes", {22'd0, strb}, 32'd0);
         chk("bp_res_valid", {31'd0, bus.res_valid}, 32'd1);
      end
      bus.start = 1'b0;
      bus.res_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_idle", {31'd0, bus.start_ready}, 32'd1);
      chk("bp_release_valid", {31'd0, bus.res_valid}, 32'd0);
      run_op(16'hFFF3, 16'h0011, 1'b1, prod, lat, n_lda, n_decr);
      chk("bp_next_product", prod, smul(16'hFFF3, 16'h0011));
      chk("bp_next_latency", lat, 36 + booth_ops(16'h0011));
      // asynchronous reset landing in a SHIFT cycle
      @(negedge clk);
      bus.start = 1'b1; bus.multiplicand = 16'h1234; bus.multiplier = 16'h5678;
      @(negedge clk);
      bus.start = 1'b0;
      k = 0;
      while (!sfta && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("mid_reached_shift", {31'd0, sfta}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_strobes", {22'd0, strb}, 32'd0);
      chk("mid_rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
      chk("mid_rst_start_ready", {31'd0, bus.start_ready}, 32'd1);
      chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(16'h0005, 16'h0006, 1'b1, prod, lat, n_lda, n_decr);
      chk("mid_after_product", prod, 32'h0000001E);
      chk("mid_after_latency", lat, 38);
      for (int r = 0; r < 1000; r++) begin
         rmc = 16'($urandom);
         rmp = 16'($urandom);
         run_op(rmc, rmp, 1'b1, prod, lat, n_lda, n_decr);
         chk("rand_product", prod, smul(rmc, rmp));
         chk("rand_latency", lat, 36 + booth_ops(rmp));
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
